// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared states, opcode constants and ALUOp encodings for multicycle_ctrl
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MUL    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // CLS_ALU_R is the all-zero encoding so a reset op register reads as a plain ALU op
  typedef enum logic [1:0] {
    CLS_ALU_R = 2'd0,
    CLS_ALU_I = 2'd1,
    CLS_MUL   = 2'd2,
    CLS_NOP   = 2'd3
  } op_class_t;

  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_ITYPE   = 7'b0010011;
  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // ALUOp driven while an instruction of the given class sits in EXEC or WB
  function automatic logic [1:0] alu_op_for(input op_class_t cls);
    case (cls)
      CLS_ALU_R: alu_op_for = ALUOP_R;
      CLS_ALU_I: alu_op_for = ALUOP_I;
      default:   alu_op_for = ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_op_class.sv
// rtl/mc_op_class.sv - opcode/funct7 classifier; MUL class only when MULTICYCLE_MUL_EN is defined
module mc_op_class
  import multicycle_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [6:0] i_funct7,
  output op_class_t  o_class
);

`ifndef MULTICYCLE_MUL_EN
  logic w_unused_funct7;
  assign w_unused_funct7 = ^i_funct7;
`endif

  // anything that is neither R-type nor I-type retires nothing and is treated as a NOP
  always_comb begin
    o_class = CLS_NOP;
    if (i_op == OP_RTYPE) begin
`ifdef MULTICYCLE_MUL_EN
      o_class = (i_funct7 == FUNCT7_MUL) ? CLS_MUL : CLS_ALU_R;
`else
      o_class = CLS_ALU_R;
`endif
    end else if (i_op == OP_ITYPE) begin
      o_class = CLS_ALU_I;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32 sequencer (FETCH/DECODE/EXEC|MUL/WB); MUL path under MULTICYCLE_MUL_EN
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MUL_TIMEOUT = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       Op_i,
  input  logic [6:0]       Funct7_i,
  input  logic             MulDone_i,
  output logic             PCWrite_o,
  output logic             IRWrite_o,
  output logic             ALUSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic             RegWrite_o,
  output logic             MulStart_o,
  output logic             Busy_o,
  output logic             Err_o,
  output logic [CNT_W-1:0] RetireCnt_o
);

  state_t           r_state;
  op_class_t        r_cls;
  logic [CNT_W-1:0] r_retire;
  op_class_t        w_cls;

  mc_op_class u_op_class (
    .i_op     (Op_i),
    .i_funct7 (Funct7_i),
    .o_class  (w_cls)
  );

`ifdef MULTICYCLE_MUL_EN
  localparam int WAIT_W = (MUL_TIMEOUT > 2) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(MUL_TIMEOUT - 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_timeout;
  logic              r_err;
  logic              w_mul_done;
  logic              w_mul_tc;

  // a done in the first MUL cycle belongs to no request of ours and is dropped
  assign w_mul_done = MulDone_i && (r_wait != '0);
  assign w_mul_tc   = (r_wait == WAIT_TC);
`else
  localparam int unused_mul_timeout = MUL_TIMEOUT;
  logic w_unused_mul_done;
  assign w_unused_mul_done = MulDone_i;
`endif

  // state sequencing, op register, retire counter and multiplier wait/timeout tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cls     <= CLS_ALU_R;
      r_retire  <= '0;
`ifdef MULTICYCLE_MUL_EN
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) r_state <= S_FETCH;
        end
        S_FETCH: begin
          // the op register is captured as DECODE is entered so every DECODE
          // output is a function of registered state alone
          r_cls     <= w_cls;
`ifdef MULTICYCLE_MUL_EN
          r_timeout <= 1'b0;
`endif
          r_state   <= S_DECODE;
        end
        S_DECODE: begin
          case (r_cls)
            CLS_NOP: r_state <= start_i ? S_FETCH : S_IDLE;
`ifdef MULTICYCLE_MUL_EN
            CLS_MUL: begin
              r_wait  <= '0;
              r_state <= S_MUL;
            end
`endif
            default: r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          r_state <= S_WB;
        end
`ifdef MULTICYCLE_MUL_EN
        S_MUL: begin
          r_wait <= r_wait + WAIT_W'(1);
          if (w_mul_done) begin
            r_state <= S_WB;
          end else if (w_mul_tc) begin
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= S_WB;
          end
        end
`endif
        S_WB: begin
`ifdef MULTICYCLE_MUL_EN
          if (!r_timeout) r_retire <= r_retire + CNT_W'(1);
`else
          r_retire <= r_retire + CNT_W'(1);
`endif
          r_state <= start_i ? S_FETCH : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode from the state and op registers only
  always_comb begin
    PCWrite_o  = 1'b0;
    IRWrite_o  = 1'b0;
    ALUSrc_o   = 1'b0;
    ALUOp_o    = ALUOP_ADD;
    RegWrite_o = 1'b0;
    MulStart_o = 1'b0;
    case (r_state)
      S_FETCH:  IRWrite_o = 1'b1;
      S_DECODE: PCWrite_o = (r_cls == CLS_NOP);
      S_EXEC: begin
        ALUSrc_o = (r_cls == CLS_ALU_I);
        ALUOp_o  = alu_op_for(r_cls);
      end
`ifdef MULTICYCLE_MUL_EN
      S_MUL:    MulStart_o = (r_wait == '0);
`endif
      S_WB: begin
        ALUSrc_o  = (r_cls == CLS_ALU_I);
        ALUOp_o   = alu_op_for(r_cls);
        PCWrite_o = 1'b1;
`ifdef MULTICYCLE_MUL_EN
        RegWrite_o = !r_timeout;
`else
        RegWrite_o = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign Busy_o      = (r_state != S_IDLE);
  assign RetireCnt_o = r_retire;
`ifdef MULTICYCLE_MUL_EN
  assign Err_o = r_err;
`else
  assign Err_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed bench for multicycle_ctrl with a per-instruction trace model
module tb_multicycle_ctrl;

  localparam int CNT_W       = 4;
  localparam int MUL_TIMEOUT = 32;

  localparam logic [6:0] OPR  = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPLD = 7'b0000011;
  localparam logic [6:0] F7Z  = 7'b0000000;
  localparam logic [6:0] F7M  = 7'b0000001;

`ifdef MULTICYCLE_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct packed {
    logic             pcw;
    logic             irw;
    logic             src;
    logic [1:0]       aop;
    logic             rw;
    logic             ms;
    logic             bz;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_i, start_i, MulDone_i;
  logic [6:0]       Op_i, Funct7_i;
  logic             PCWrite_o, IRWrite_o, ALUSrc_o, RegWrite_o, MulStart_o, Busy_o, Err_o;
  logic [1:0]       ALUOp_o;
  logic [CNT_W-1:0] RetireCnt_o;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_mst  = 0;
  int   cyc    = 0;
  int   m_cnt  = 0;
  bit   m_err  = 1'b0;
  exp_t q[$];
  exp_t ce, ca;

  multicycle_ctrl #(.CNT_W(CNT_W), .MUL_TIMEOUT(MUL_TIMEOUT)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .Op_i        (Op_i),
    .Funct7_i    (Funct7_i),
    .MulDone_i   (MulDone_i),
    .PCWrite_o   (PCWrite_o),
    .IRWrite_o   (IRWrite_o),
    .ALUSrc_o    (ALUSrc_o),
    .ALUOp_o     (ALUOp_o),
    .RegWrite_o  (RegWrite_o),
    .MulStart_o  (MulStart_o),
    .Busy_o      (Busy_o),
    .Err_o       (Err_o),
    .RetireCnt_o (RetireCnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (MulStart_o) n_mst <= n_mst + 1;

  // single trace compare: one expected vector per cycle the model has described
  always @(negedge clk) begin
    if (q.size() != 0) begin
      ce = q.pop_front();
      ca = {PCWrite_o, IRWrite_o, ALUSrc_o, ALUOp_o, RegWrite_o, MulStart_o, Busy_o, Err_o, RetireCnt_o};
      n_vec++;
      if (ca !== ce) begin
        n_fail++;
        $display("FAIL trace cyc=%0d got pc=%b ir=%b src=%b aop=%b rw=%b ms=%b bz=%b err=%b cnt=%0d want pc=%b ir=%b src=%b aop=%b rw=%b ms=%b bz=%b err=%b cnt=%0d",
                 cyc, ca.pcw, ca.irw, ca.src, ca.aop, ca.rw, ca.ms, ca.bz, ca.err, ca.cnt,
                 ce.pcw, ce.irw, ce.src, ce.aop, ce.rw, ce.ms, ce.bz, ce.err, ce.cnt);
      end
    end
  end

  function automatic int cls_of(input logic [6:0] op, input logic [6:0] f7);
    if (op == OPR) return (MUL_ON && f7 == F7M) ? 2 : 0;
    if (op == OPI) return 1;
    return 3;
  endfunction

  function automatic exp_t mk(input logic pcw, input logic irw, input logic src,
                              input logic [1:0] aop, input logic rw, input logic ms, input logic bz);
    exp_t e;
    e.pcw = pcw; e.irw = irw; e.src = src; e.aop = aop;
    e.rw = rw; e.ms = ms; e.bz = bz; e.err = m_err;
    e.cnt = m_cnt[CNT_W-1:0];
    return e;
  endfunction

  task automatic pin(input string nm, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic step(input logic st, input logic dn, input logic rs, input exp_t e);
    @(posedge clk);
    #1;
    start_i = st; MulDone_i = dn; rst_i = rs;
    q.push_back(e);
  endtask

  task automatic idle(input logic st);
    step(st, 1'b0, 1'b0, mk(0, 0, 0, 2'b00, 0, 0, 0));
  endtask

  task automatic recover();
    m_cnt = 0; m_err = 1'b0;
    step(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 2'b00, 0, 0, 0));
  endtask

  // describes one instruction cycle by cycle from the current FETCH cycle;
  // abort_at >= 0 raises rst_i during that cycle index and stops there
  task automatic issue(input logic [6:0] op, input logic [6:0] f7, input int done_at,
                       input bit done_first, input bit mid, input bit last, input int abort_at);
    int  c, ci, i;
    bit  r, dn, to, fin;
    logic       src;
    logic [1:0] aop;
    c = cls_of(op, f7);
    Op_i = op; Funct7_i = f7;
    ci = 0; to = 1'b0;
    r = (ci == abort_at);
    step(mid, 1'b0, r, mk(0, 1, 0, 2'b00, 0, 0, 1));
    if (r) return;
    ci++;
    r = (ci == abort_at);
    if (c == 3) begin
      step(!last, 1'b0, r, mk(1, 0, 0, 2'b00, 0, 0, 1));
      return;
    end
    step(mid, 1'b0, r, mk(0, 0, 0, 2'b00, 0, 0, 1));
    if (r) return;
    ci++;
    src = (c == 1);
    aop = (c == 0) ? 2'b10 : (c == 1) ? 2'b11 : 2'b00;
    if (c == 2) begin
      i = 0; fin = 1'b0; to = 1'b1;
      while (!fin) begin
        dn = (i == done_at) || (i == 0 && done_first);
        r  = (ci == abort_at);
        step(mid, dn, r, mk(0, 0, 0, 2'b00, 0, (i == 0), 1));
        if (r) return;
        ci++;
        if (dn && i >= 1) begin
          to = 1'b0; fin = 1'b1;
        end else if (i == MUL_TIMEOUT - 1) begin
          fin = 1'b1;
        end
        i++;
      end
      if (to) m_err = 1'b1;
    end else begin
      r = (ci == abort_at);
      step(mid, 1'b0, r, mk(0, 0, src, aop, 0, 0, 1));
      if (r) return;
      ci++;
    end
    r = (ci == abort_at);
    step(!last, 1'b0, r, mk(1, 0, src, aop, !to, 0, 1));
    if (r) return;
    if (!to) m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  int ms0;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; MulDone_i = 1'b0; Op_i = '0; Funct7_i = '0;
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 2'b00, 0, 0, 0));
    pin("reset_cnt", int'(RetireCnt_o), 0);
    pin("reset_busy", int'(Busy_o), 0);

    // single R-type ALU op
    idle(1'b1);
    issue(OPR, F7Z, -1, 1'b0, 1'b1, 1'b1, -1);
    idle(1'b0);
    pin("alu_r_cnt", int'(RetireCnt_o), 1);

    // three back-to-back I-type ops, start_i low mid-instruction
    idle(1'b1);
    issue(OPI, F7Z, -1, 1'b0, 1'b0, 1'b0, -1);
    issue(OPI, F7Z, -1, 1'b0, 1'b0, 1'b0, -1);
    issue(OPI, F7Z, -1, 1'b0, 1'b0, 1'b1, -1);
    idle(1'b0);
    pin("alu_i_cnt", int'(RetireCnt_o), 4);

    // MUL with done five cycles after start
    ms0 = n_mst;
    idle(1'b1);
    issue(OPR, F7M, 5, 1'b0, 1'b1, 1'b1, -1);
    idle(1'b0);
    pin("mul_start_pulses", n_mst - ms0, MUL_ON ? 1 : 0);
    pin("mul_err", int'(Err_o), 0);
    pin("mul_cnt", int'(RetireCnt_o), 5);

    // done in first cycle ignored; done on the terminal count wins over timeout
    idle(1'b1);
    issue(OPR, F7M, MUL_TIMEOUT - 1, 1'b1, 1'b1, 1'b1, -1);
    idle(1'b0);
    pin("mul_tie_err", int'(Err_o), 0);
    pin("mul_tie_cnt", int'(RetireCnt_o), 6);

    // MUL that never completes
    idle(1'b1);
    issue(OPR, F7M, -1, 1'b0, 1'b1, 1'b1, -1);
    idle(1'b0);
    pin("timeout_err", int'(Err_o), MUL_ON ? 1 : 0);
    pin("timeout_cnt", int'(RetireCnt_o), MUL_ON ? 6 : 7);

    // unsupported opcode followed directly by an I-type op
    idle(1'b1);
    issue(OPLD, F7Z, -1, 1'b0, 1'b1, 1'b0, -1);
    issue(OPI, F7Z, -1, 1'b0, 1'b1, 1'b1, -1);
    idle(1'b0);
    pin("nop_cnt", int'(RetireCnt_o), MUL_ON ? 7 : 8);

    // reset while in EXEC
    idle(1'b1);
    issue(OPR, F7Z, -1, 1'b0, 1'b1, 1'b1, 2);
    recover();
    pin("rst_exec_cnt", int'(RetireCnt_o), 0);
    pin("rst_exec_err", int'(Err_o), 0);

    // reset while in MUL (WB in the build without the multiplier)
    idle(1'b1);
    issue(OPI, F7Z, -1, 1'b0, 1'b1, 1'b1, -1);
    idle(1'b0);
    pin("pre_rst_mul_cnt", int'(RetireCnt_o), 1);
    idle(1'b1);
    issue(OPR, F7M, -1, 1'b0, 1'b1, 1'b1, 3);
    recover();
    pin("rst_mul_cnt", int'(RetireCnt_o), 0);

    // counter wrap: 16 retires on a 4-bit counter return to the start value
    idle(1'b1);
    for (int k = 0; k < 3; k++) issue(OPI, F7Z, -1, 1'b0, 1'b0, (k == 2), -1);
    idle(1'b0);
    pin("wrap_start", int'(RetireCnt_o), 3);
    idle(1'b1);
    for (int k = 0; k < 16; k++) issue((k % 2 == 0) ? OPR : OPI, F7Z, -1, 1'b0, 1'b1, (k == 15), -1);
    idle(1'b0);
    pin("wrap_back", int'(RetireCnt_o), 3);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
